sram_fifo_ctrl: RTL
===================

Name: sram_fifo_ctrl

Overview:
- Sequencing controller that turns one simple dual-port SRAM (1 write port, 1 registered read port) into a first-in, first-out queue (FIFO).
- Input is a valid/ready stream; output is a valid/ready stream.
- The controller drives the SRAM write and read ports. The SRAM is instantiated outside this block and wired to the sram_* ports.
- Used between stream producers and consumers in the accelerator datapath where register FIFOs are too costly.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 256, SRAM entry count; must be a power of two and at least 2.
- ADDR_WIDTH, $clog2(DEPTH), SRAM address width.
- LVL_WIDTH, $clog2(DEPTH+2), width of the occupancy output.

Ports:
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush; discards all contents.
- s_valid  in  1  input word valid.
- s_ready  out  1  controller can accept a word.
- s_data  in  WIDTH  input word.
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer accepts the word.
- m_data  out  WIDTH  output word; driven directly from sram_dout.
- level  out  LVL_WIDTH  total words held (SRAM plus output slot).
- sram_wen  out  1  SRAM write enable.
- sram_waddr  out  ADDR_WIDTH  SRAM write address.
- sram_din  out  WIDTH  SRAM write data; equals s_data.
- sram_ren  out  1  SRAM read enable.
- sram_raddr  out  ADDR_WIDTH  SRAM read address.
- sram_dout  in  WIDTH  SRAM registered read data.

Behaviour:
- SRAM contract:
  - Write at clock edge when wen is high.
  - Read data appears on dout the edge after ren is high.
  - dout holds its value while ren is low.
- State, all reset to 0 by asynchronous assertion of rstn:
  - wptr and rptr (ADDR_WIDTH bits, wrap modulo DEPTH).
  - cnt (0..DEPTH): words stored in the SRAM.
  - m_valid register.
- Reset output values:
  - s_ready=0 while rstn is low; s_ready=1 from the first cycle after release.
  - m_valid=0, level=0, sram_wen=0, sram_ren=0, both addresses 0.
- Write side:
  - s_ready = (cnt < DEPTH) and not clear.
  - push = s_valid and s_ready.
  - sram_wen = push, sram_waddr = wptr, sram_din = s_data.
  - wptr increments on push.
- Read side:
  - pop_slot = m_valid and m_ready.
  - sram_ren = (cnt > 0) and (not m_valid or m_ready) and not clear.
  - sram_raddr = rptr; rptr increments when sram_ren is high.
- Output slot:
  - m_valid next = 1 if sram_ren; else 0 if pop_slot; else unchanged.
  - m_data = sram_dout. It is stable while m_valid=1 and m_ready=0, because ren stays low.
- Counter:
  - cnt next = cnt + push − sram_ren.
  - Simultaneous push and read leave cnt unchanged.
- Read/write addresses never collide: a read only targets entries counted in cnt, and a written word enters cnt on the next cycle.
- Latency:
  - Word pushed at edge t into an empty FIFO: ren at t+1, m_valid=1 after edge t+2.
  - Throughput is one word per cycle in steady state, including with DEPTH full and m_ready held high.
- level = cnt + m_valid; maximum DEPTH+1.
- Boundary conditions:
  - cnt==DEPTH: s_ready=0. A pop that issues ren in the same cycle does not raise s_ready until the next cycle (no combinational ready-through).
  - cnt==0 with m_valid and m_ready high: m_valid falls next cycle, no read is issued.
  - wptr and rptr wrap from DEPTH−1 to 0.
  - clear: on the next edge wptr=rptr=cnt=0 and m_valid=0. During the clear cycle there is no push and no ren; an in-flight read is discarded.
  - rstn asserted mid-transfer: all state cleared immediately; no ordering guarantee for words in flight.
- Ordering: output order equals accepted input order; no word is dropped or duplicated except by clear or reset.

Test Plan (DEPTH=4, WIDTH=8 unless noted):
- Fill then drain:
  - Stimulus: push 0x11,0x22,0x33,0x44,0x55 with m_ready=0.
  - Required: all five accepted; level=5 and s_ready=0 after the fifth push.
  - Stimulus: m_ready=1.
  - Required: output 0x11..0x55 in order, one per cycle; level returns to 0.
- Latency:
  - Stimulus: single push of 0xA5 at cycle 0 into an empty FIFO.
  - Required: sram_ren=1 at cycle 1; m_valid=1 with m_data=0xA5 at cycle 2.
- Streaming:
  - Stimulus: s_valid and m_ready held high, 20 words 0..19.
  - Required: output 0..19 in order, no bubbles after the first arrival, level never exceeds 2.
- Backpressure stability:
  - Stimulus: m_ready toggles 1,0,0,1 while streaming.
  - Required: m_data unchanged during the m_ready=0 cycles; no sram_ren while the slot is blocked.
- Wrap:
  - Stimulus: push/pop 10 words with occupancy about 3.
  - Required: raddr and waddr pass 3→0 at least twice; data intact.
- Clear and reset:
  - Stimulus: with level=3, pulse clear for one cycle.
  - Required: next cycle level=0, m_valid=0; a subsequent push of 0x7E emerges first.
  - Stimulus: assert rstn low mid-stream.
  - Required: m_valid=0, level=0 and s_ready=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: sequences an external simple dual-port SRAM (one write port,
// one registered read port) as a FIFO. The SRAM read register is the output
// slot, so m_data comes straight from sram_dout.
module sram_fifo_ctrl #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
   parameter int unsigned LVL_WIDTH  = $clog2(DEPTH + 2)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  clear,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [WIDTH-1:0]      s_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [WIDTH-1:0]      m_data,
   output logic [LVL_WIDTH-1:0]  level,
   output logic                  sram_wen,
   output logic [ADDR_WIDTH-1:0] sram_waddr,
   output logic [WIDTH-1:0]      sram_din,
   output logic                  sram_ren,
   output logic [ADDR_WIDTH-1:0] sram_raddr,
   input  logic [WIDTH-1:0]      sram_dout
);

   localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
   localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

   logic [ADDR_WIDTH-1:0] wptr;
   logic [ADDR_WIDTH-1:0] rptr;
   logic [CNT_WIDTH-1:0]  cnt;
   logic                  run;
   logic                  push;
   logic                  pop_slot;

   // Handshake decode and SRAM port drive; ready is held low until the
   // first edge after reset release.
   always_comb begin
      s_ready    = 1'b0;
      push       = 1'b0;
      pop_slot   = 1'b0;
      sram_ren   = 1'b0;
      s_ready    = run && (cnt < FULL_CNT) && !clear;
      push       = s_valid && s_ready;
      pop_slot   = m_valid && m_ready;
      sram_ren   = (cnt != '0) && (!m_valid || m_ready) && !clear;
      sram_wen   = push;
      sram_waddr = wptr;
      sram_din   = s_data;
      sram_raddr = rptr;
      m_data     = sram_dout;
      level      = LVL_WIDTH'(cnt) + LVL_WIDTH'(m_valid);
   end

   // Pointers, SRAM occupancy and output-slot valid; clear flushes everything.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         run     <= 1'b0;
         wptr    <= '0;
         rptr    <= '0;
         cnt     <= '0;
         m_valid <= 1'b0;
      end else begin
         run <= 1'b1;
         if (clear) begin
            wptr    <= '0;
            rptr    <= '0;
            cnt     <= '0;
            m_valid <= 1'b0;
         end else begin
            if (push) begin
               wptr <= wptr + ADDR_WIDTH'(1);
            end
            if (sram_ren) begin
               rptr <= rptr + ADDR_WIDTH'(1);
            end
            cnt <= cnt + CNT_WIDTH'(push) - CNT_WIDTH'(sram_ren);
            if (sram_ren) begin
               m_valid <= 1'b1;
            end else if (pop_slot) begin
               m_valid <= 1'b0;
            end
         end
      end
   end

endmodule
